// File: rtl/bpm_sim_pkg.sv
// Shared defaults and state encoding for the BPM simulation-buffer port-B readout scheduler.
package bpm_sim_pkg;

  localparam int DEFAULT_AW         = 10;
  localparam int DEFAULT_RD_LAT     = 2;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int FIFO_W             = 34;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } schedState_t;

endpackage

// File: rtl/sim_rd_fifo.sv
// First-word-fall-through FIFO carrying {data, first, last}; exposes occupancy for read-credit control.
module sim_rd_fifo
  import bpm_sim_pkg::*;
#(
  parameter int WIDTH = FIFO_W,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wrEn,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       rdEn,
  output logic [WIDTH-1:0]           rdData,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             rdGo;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rdGo      = rdEn && (count != '0);
  assign empty     = (count == '0);
  assign occupancy = count;
  assign rdData    = mem[rdPtr];

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) begin
        wrPtr <= nextPtr(wrPtr);
      end
      if (rdGo) begin
        rdPtr <= nextPtr(rdPtr);
      end
      case ({wrEn, rdGo})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bpm_sim_readout_sched.sv
// Reads one configured address window of the BPM simulation RAM per FOFB trigger and streams it out valid/ready.
module bpm_sim_readout_sched
  import bpm_sim_pkg::*;
#(
  parameter int AW         = DEFAULT_AW,
  parameter int RD_LAT     = DEFAULT_RD_LAT,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig,
  input  logic          enable,
  input  logic [AW-1:0] StartAddr,
  input  logic [AW-1:0] EndAddr,
  output logic          DpRamB_Read,
  output logic [11:0]   DpRamB_Address,
  input  logic [31:0]   DpRamB_Data,
  output logic [31:0]   OutData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          OutFirst,
  output logic          OutLast,
  output logic          Busy,
  output logic          FrameDone,
  output logic [31:0]   FrameCount,
  output logic [15:0]   OverrunCount
);

  schedState_t state;
  schedState_t stateNext;

  logic [AW-1:0]                       addr;
  logic [AW:0]                         issueLeft;
  logic                                firstPend;
  logic [RD_LAT-1:0]                   vPipe;
  logic [RD_LAT-1:0]                   fPipe;
  logic [RD_LAT-1:0]                   lPipe;
  logic [$clog2(FIFO_DEPTH+1)-1:0]     occ;
  logic [FIFO_W-1:0]                   fifoHead;
  logic                                fifoEmpty;
  logic                                credit;
  logic                                accept;
  logic                                lastXfer;

  // Credit counts words already buffered plus reads still in the RAM pipeline, so the FIFO can never overflow.
  assign credit   = (int'(occ) + $countones(vPipe)) < FIFO_DEPTH;
  assign OutValid = !fifoEmpty;
  assign OutData  = OutValid ? fifoHead[FIFO_W-1:2] : '0;
  assign OutFirst = OutValid && fifoHead[1];
  assign OutLast  = OutValid && fifoHead[0];
  assign lastXfer = OutValid && OutReady && fifoHead[0];
  assign Busy     = (state != IDLE);
  assign DpRamB_Address = {{(12 - AW){1'b0}}, addr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // A trigger landing on the FrameDone cycle is treated as an overrun, not a new frame.
  always_comb begin
    stateNext   = state;
    DpRamB_Read = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (trig && enable && !FrameDone) begin
          accept    = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (credit) begin
          DpRamB_Read = 1'b1;
          if (issueLeft == (AW + 1)'(1)) begin
            stateNext = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (lastXfer) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr         <= '0;
      issueLeft    <= '0;
      firstPend    <= 1'b0;
      vPipe        <= '0;
      fPipe        <= '0;
      lPipe        <= '0;
      FrameDone    <= 1'b0;
      FrameCount   <= '0;
      OverrunCount <= '0;
    end else begin
      FrameDone <= (state == DRAIN) && lastXfer;
      if ((state == DRAIN) && lastXfer) begin
        FrameCount <= FrameCount + 1'b1;
      end
      if (trig && enable && ((state != IDLE) || FrameDone) && (OverrunCount != '1)) begin
        OverrunCount <= OverrunCount + 1'b1;
      end

      // Window length wraps mod 2^AW, so End < Start reads through the top of the RAM.
      if (accept) begin
        addr      <= StartAddr;
        issueLeft <= {1'b0, EndAddr - StartAddr} + (AW + 1)'(1);
        firstPend <= 1'b1;
      end else if (DpRamB_Read) begin
        addr      <= addr + 1'b1;
        issueLeft <= issueLeft - 1'b1;
        firstPend <= 1'b0;
      end

      vPipe[0] <= DpRamB_Read;
      fPipe[0] <= DpRamB_Read && firstPend;
      lPipe[0] <= DpRamB_Read && (issueLeft == (AW + 1)'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        vPipe[i] <= vPipe[i-1];
        fPipe[i] <= fPipe[i-1];
        lPipe[i] <= lPipe[i-1];
      end
    end
  end

  sim_rd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk       (clk),
    .reset     (reset),
    .wrEn      (vPipe[RD_LAT-1]),
    .wrData    ({DpRamB_Data, fPipe[RD_LAT-1], lPipe[RD_LAT-1]}),
    .rdEn      (OutValid && OutReady),
    .rdData    (fifoHead),
    .empty     (fifoEmpty),
    .occupancy (occ)
  );

endmodule

// File: tb/tb_bpm_sim_readout_sched.sv
// Scoreboard bench for bpm_sim_readout_sched with a 2-clock-latency RAM model on port B.
module tb_bpm_sim_readout_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        trig;
  logic        enable;
  logic [9:0]  StartAddr;
  logic [9:0]  EndAddr;
  logic        DpRamB_Read;
  logic [11:0] DpRamB_Address;
  logic [31:0] DpRamB_Data;
  logic [31:0] OutData;
  logic        OutValid;
  logic        OutReady;
  logic        OutFirst;
  logic        OutLast;
  logic        Busy;
  logic        FrameDone;
  logic [31:0] FrameCount;
  logic [15:0] OverrunCount;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int trigCycle = 0;
  int firstValidCycle = -1;
  int lastXferCycle = -1;
  int doneCycle = -1;
  int doneCount = 0;
  int rdIssued = 0;
  int xfers = 0;
  int maxOutstanding = 0;
  int stallErrs = 0;
  int badAddr = 0;
  logic        prevStall = 1'b0;
  logic [33:0] prevWord = '0;
  logic [33:0] expQ [$];
  logic [31:0] ramS1;

  bpm_sim_readout_sched dut (
    .clk            (clk),
    .reset          (reset),
    .trig           (trig),
    .enable         (enable),
    .StartAddr      (StartAddr),
    .EndAddr        (EndAddr),
    .DpRamB_Read    (DpRamB_Read),
    .DpRamB_Address (DpRamB_Address),
    .DpRamB_Data    (DpRamB_Data),
    .OutData        (OutData),
    .OutValid       (OutValid),
    .OutReady       (OutReady),
    .OutFirst       (OutFirst),
    .OutLast        (OutLast),
    .Busy           (Busy),
    .FrameDone      (FrameDone),
    .FrameCount     (FrameCount),
    .OverrunCount   (OverrunCount)
  );

  always #5 clk = ~clk;

  // RAM content carries the address twice so any address bit error shows in the data.
  function automatic logic [31:0] ramWord(input logic [9:0] a);
    return {6'h2B, a, 6'h15, a};
  endfunction

  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (DpRamB_Read) ramS1 <= ramWord(DpRamB_Address[9:0]);
    DpRamB_Data <= ramS1;
  end

  // Scoreboard monitor: pops one expected word per transfer, tracks stalls and outstanding words.
  always @(negedge clk) begin
    logic [33:0] exp;
    if (!reset) begin
      if (DpRamB_Read) begin
        rdIssued++;
        if (DpRamB_Address[11:10] != 2'b00) badAddr++;
      end
      if (prevStall && (!OutValid || {OutData, OutFirst, OutLast} !== prevWord)) stallErrs++;
      if (OutValid && firstValidCycle < 0) firstValidCycle = cycleCnt;
      if (OutValid && OutReady) begin
        xfers++;
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpectedWord: got %h, required no word", {OutData, OutFirst, OutLast});
        end else begin
          exp = expQ.pop_front();
          if ({OutData, OutFirst, OutLast} !== exp) begin
            failures++;
            $display("[TB] FAIL word: got %h, required %h", {OutData, OutFirst, OutLast}, exp);
          end
        end
        if (OutLast) lastXferCycle = cycleCnt;
      end
      if (FrameDone) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cycleCnt;
      end
      if (rdIssued - xfers > maxOutstanding) maxOutstanding = rdIssued - xfers;
      prevStall = OutValid && !OutReady;
      prevWord  = {OutData, OutFirst, OutLast};
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic startFrame(input logic [9:0] s, input logic [9:0] e);
    logic [9:0] d;
    logic [9:0] a;
    int n;
    d = e - s;
    n = int'(d) + 1;
    for (int i = 0; i < n; i++) begin
      a = s + 10'(i);
      expQ.push_back({ramWord(a), (i == 0), (i == n - 1)});
    end
    firstValidCycle = -1;
    lastXferCycle = -1;
    doneCycle = -1;
    doneCount = 0;
    rdIssued = 0;
    xfers = 0;
    maxOutstanding = 0;
    stallErrs = 0;
    StartAddr = s;
    EndAddr = e;
    trig = 1'b1;
    trigCycle = cycleCnt;
    @(posedge clk); #1;
    trig = 1'b0;
  endtask

  task automatic pulseTrig(input logic [9:0] s, input logic [9:0] e);
    StartAddr = s;
    EndAddr = e;
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int n = 0; n < budget && doneCycle < 0; n++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; trig = 1'b0; enable = 1'b0; OutReady = 1'b0;
    StartAddr = '0; EndAddr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({OutValid, Busy, FrameDone, DpRamB_Read, OutFirst, OutLast} !== 6'b0) begin
      failures++; $display("[TB] FAIL resetFlags: got %b, required 000000",
                           {OutValid, Busy, FrameDone, DpRamB_Read, OutFirst, OutLast});
    end
    checks++;
    if (OutData !== 32'h0) begin failures++; $display("[TB] FAIL resetData: got %h, required 0", OutData); end
    checks++;
    if (FrameCount !== 32'h0) begin failures++; $display("[TB] FAIL resetFrameCount: got %0d, required 0", FrameCount); end
    checks++;
    if (OverrunCount !== 16'h0) begin failures++; $display("[TB] FAIL resetOverrun: got %0d, required 0", OverrunCount); end
    checks++;
    if (DpRamB_Address !== 12'h0) begin failures++; $display("[TB] FAIL resetAddr: got %h, required 0", DpRamB_Address); end
    reset = 1'b0; enable = 1'b1; OutReady = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    startFrame(10'd0, 10'd359);
    waitDone(1000);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (doneCycle < 0) begin failures++; $display("[TB] FAIL basicTimeout: got no FrameDone, required one"); end
    checks++;
    if (firstValidCycle - trigCycle != 4) begin failures++; $display("[TB] FAIL basicFirstValid: got %0d, required 4", firstValidCycle - trigCycle); end
    checks++;
    if (lastXferCycle - trigCycle != 363) begin failures++; $display("[TB] FAIL basicLastXfer: got %0d, required 363", lastXferCycle - trigCycle); end
    checks++;
    if (doneCycle - trigCycle != 364) begin failures++; $display("[TB] FAIL basicDone: got %0d, required 364", doneCycle - trigCycle); end
    checks++;
    if (doneCount != 1) begin failures++; $display("[TB] FAIL basicDonePulse: got %0d, required 1", doneCount); end
    checks++;
    if (FrameCount !== 32'd1) begin failures++; $display("[TB] FAIL basicFrameCount: got %0d, required 1", FrameCount); end
    checks++;
    if (expQ.size() != 0 || Busy !== 1'b0) begin failures++; $display("[TB] FAIL basicEnd: got left=%0d busy=%b, required 0 0", expQ.size(), Busy); end
  endtask

  task automatic test_wrap;
    startFrame(10'd1020, 10'd3);
    waitDone(200);
    checks++;
    if (doneCycle - trigCycle != 12) begin failures++; $display("[TB] FAIL wrapDone: got %0d, required 12", doneCycle - trigCycle); end
    checks++;
    if (expQ.size() != 0 || xfers != 8) begin failures++; $display("[TB] FAIL wrapWords: got xfers=%0d left=%0d, required 8 0", xfers, expQ.size()); end
    checks++;
    if (FrameCount !== 32'd2 || badAddr != 0) begin failures++; $display("[TB] FAIL wrapCount: got fc=%0d badAddr=%0d, required 2 0", FrameCount, badAddr); end
  endtask

  task automatic test_single;
    startFrame(10'd5, 10'd5);
    waitDone(100);
    checks++;
    if (firstValidCycle - trigCycle != 4 || doneCycle - trigCycle != 5) begin
      failures++; $display("[TB] FAIL singleTiming: got valid=%0d done=%0d, required 4 5",
                           firstValidCycle - trigCycle, doneCycle - trigCycle);
    end
    checks++;
    if (expQ.size() != 0 || xfers != 1 || FrameCount !== 32'd3) begin
      failures++; $display("[TB] FAIL singleWords: got xfers=%0d left=%0d fc=%0d, required 1 0 3", xfers, expQ.size(), FrameCount);
    end
  endtask

  task automatic test_backpressure;
    OutReady = ($urandom_range(0, 99) < 30);
    startFrame(10'd0, 10'd63);
    for (int n = 0; n < 3000 && doneCycle < 0; n++) begin
      OutReady = ($urandom_range(0, 99) < 30);
      @(posedge clk); #1;
    end
    OutReady = 1'b1;
    checks++;
    if (doneCycle < 0) begin failures++; $display("[TB] FAIL bpTimeout: got no FrameDone, required one"); end
    checks++;
    if (xfers != 64 || expQ.size() != 0) begin failures++; $display("[TB] FAIL bpWords: got xfers=%0d left=%0d, required 64 0", xfers, expQ.size()); end
    checks++;
    if (stallErrs != 0) begin failures++; $display("[TB] FAIL bpStable: got %0d changes while stalled, required 0", stallErrs); end
    checks++;
    if (maxOutstanding != 4) begin failures++; $display("[TB] FAIL bpCredit: got max outstanding %0d, required 4", maxOutstanding); end
    checks++;
    if (FrameCount !== 32'd4) begin failures++; $display("[TB] FAIL bpFrameCount: got %0d, required 4", FrameCount); end
  endtask

  task automatic test_overrun;
    int readsBefore;
    startFrame(10'd0, 10'd359);
    repeat (9) @(posedge clk);
    #1;
    pulseTrig(10'd500, 10'd510);
    checks++;
    if (OverrunCount !== 16'd1) begin failures++; $display("[TB] FAIL overrunCount: got %0d, required 1", OverrunCount); end
    waitDone(1000);
    checks++;
    if (doneCycle - trigCycle != 364 || expQ.size() != 0 || xfers != 360) begin
      failures++; $display("[TB] FAIL overrunFrame: got done=%0d xfers=%0d left=%0d, required 364 360 0",
                           doneCycle - trigCycle, xfers, expQ.size());
    end
    enable = 1'b0;
    readsBefore = rdIssued;
    pulseTrig(10'd0, 10'd7);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || rdIssued != readsBefore) begin failures++; $display("[TB] FAIL disabledTrig: got busy=%b reads=%0d, required 0 %0d", Busy, rdIssued, readsBefore); end
    checks++;
    if (OverrunCount !== 16'd1 || FrameCount !== 32'd5) begin
      failures++; $display("[TB] FAIL disabledCounts: got ov=%0d fc=%0d, required 1 5", OverrunCount, FrameCount);
    end
    enable = 1'b1;
  endtask

  task automatic test_back_to_back;
    bit seen;
    seen = 1'b0;
    startFrame(10'd10, 10'd13);
    for (int n = 0; n < 50 && !seen; n++) begin
      @(posedge clk); #1;
      seen = FrameDone;
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL b2bTimeout: got no FrameDone, required one"); end
    pulseTrig(10'd20, 10'd21);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (OverrunCount !== 16'd2 || Busy !== 1'b0 || doneCount != 1) begin
      failures++; $display("[TB] FAIL doneCycleTrig: got ov=%0d busy=%b done=%0d, required 2 0 1", OverrunCount, Busy, doneCount);
    end
    checks++;
    if (FrameCount !== 32'd6 || expQ.size() != 0) begin failures++; $display("[TB] FAIL b2bCount: got fc=%0d left=%0d, required 6 0", FrameCount, expQ.size()); end
    startFrame(10'd30, 10'd31);
    waitDone(100);
    checks++;
    if (doneCycle - trigCycle != 6 || FrameCount !== 32'd7 || expQ.size() != 0) begin
      failures++; $display("[TB] FAIL b2bNext: got done=%0d fc=%0d left=%0d, required 6 7 0", doneCycle - trigCycle, FrameCount, expQ.size());
    end
  endtask

  task automatic test_reset_midframe;
    startFrame(10'd0, 10'd359);
    for (int n = 0; n < 500 && xfers < 100; n++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({OutValid, Busy, FrameDone, DpRamB_Read, OutFirst, OutLast} !== 6'b0 || OutData !== 32'h0) begin
      failures++; $display("[TB] FAIL midResetOutputs: got flags=%b data=%h, required 000000 0",
                           {OutValid, Busy, FrameDone, DpRamB_Read, OutFirst, OutLast}, OutData);
    end
    checks++;
    if (FrameCount !== 32'd0 || OverrunCount !== 16'd0) begin
      failures++; $display("[TB] FAIL midResetCounters: got fc=%0d ov=%0d, required 0 0", FrameCount, OverrunCount);
    end
    expQ.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (doneCycle >= 0) begin failures++; $display("[TB] FAIL midResetDone: got FrameDone at %0d, required none", doneCycle); end
    startFrame(10'd0, 10'd359);
    waitDone(1000);
    checks++;
    if (doneCycle - trigCycle != 364 || xfers != 360 || expQ.size() != 0 || FrameCount !== 32'd1) begin
      failures++; $display("[TB] FAIL postResetFrame: got done=%0d xfers=%0d left=%0d fc=%0d, required 364 360 0 1",
                           doneCycle - trigCycle, xfers, expQ.size(), FrameCount);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_single();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
